// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array controller: state encodings,
// default array geometry and the index-width helper.
package systolic_ctrl_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DATA_SIZE      = 8;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_LOAD_W = 2'd1,
    CTRL_RUN    = 2'd2,
    CTRL_DONE   = 2'd3
  } ctrl_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Combinational skew decode: which PE rows see a live activation element and
// which bottom-edge columns carry a finished result at RUN cycle t.
module systolic_skew_gen #(
  parameter int N     = 4,
  parameter int LEN_W = 8,
  parameter int TW    = 11
) (
  input  logic [TW-1:0]    t,
  input  logic [LEN_W-1:0] k,
  output logic [N-1:0]     a_row_valid,
  output logic [N-1:0]     out_col_valid
);

  logic [TW-1:0] k_ext;
  assign k_ext = TW'(k);

  // Row i lags row 0 by i cycles; column j's result exits N+j cycles later.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam logic [TW-1:0] ROW_OFS = TW'(i);
    localparam logic [TW-1:0] COL_OFS = TW'(N + i);
    assign a_row_valid[i]   = (t >= ROW_OFS) && ((t - ROW_OFS) < k_ext);
    assign out_col_valid[i] = (t >= COL_OFS) && ((t - COL_OFS) < k_ext);
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary PE array sequencer: weight load, skewed activation
// streaming, drain and output-valid flags. Optional abort: SYSTOLIC_CTRL_ABORT_EN.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int LEN_W      = 8,
  localparam int AW        = idx_w(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SYSTOLIC_CTRL_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_zero_w,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         w_addr,
  output logic [ARRAY_SIZE-1:0] w_row_en,
  output logic                  z_weight,
  output logic                  go,
  output logic [LEN_W-1:0]      a_addr,
  output logic [ARRAY_SIZE-1:0] a_row_valid,
  output logic [ARRAY_SIZE-1:0] out_col_valid
);

  localparam int TW = LEN_W + AW + 1;

  ctrl_state_e     state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic            zw_q, zw_d;
  logic            abort_i;
  logic [TW-1:0]   run_last;

`ifdef SYSTOLIC_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign run_last = TW'(k_q) + TW'(2 * ARRAY_SIZE - 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTRL_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      zw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      zw_q    <= zw_d;
    end
  end

  // One counter serves as row index in LOAD_W and as t in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    zw_d    = zw_q;
    case (state_q)
      CTRL_IDLE: begin
        if (start) begin
          k_d   = cfg_len;
          zw_d  = cfg_zero_w;
          cnt_d = '0;
          if (cfg_len == '0)   state_d = CTRL_DONE;
          else if (cfg_zero_w) state_d = CTRL_RUN;
          else                 state_d = CTRL_LOAD_W;
        end
      end
      CTRL_LOAD_W: begin
        if (cnt_q == TW'(ARRAY_SIZE - 1)) begin
          state_d = CTRL_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      CTRL_RUN: begin
        if (cnt_q == run_last) begin
          state_d = CTRL_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      CTRL_DONE: begin
        state_d = CTRL_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = CTRL_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_i && (state_q == CTRL_LOAD_W || state_q == CTRL_RUN)) begin
      state_d = CTRL_IDLE;
      cnt_d   = '0;
    end
  end

  logic [ARRAY_SIZE-1:0] arv_raw, ocv_raw;

  systolic_skew_gen #(
    .N     (ARRAY_SIZE),
    .LEN_W (LEN_W),
    .TW    (TW)
  ) u_skew (
    .t             (cnt_d),
    .k             (k_d),
    .a_row_valid   (arv_raw),
    .out_col_valid (ocv_raw)
  );

  // Outputs are decoded from next-state so they register in step with it.
  logic                  busy_d, done_d, go_d, zw_out_d;
  logic [AW-1:0]         w_addr_d;
  logic [ARRAY_SIZE-1:0] w_row_en_d, arv_d, ocv_d;
  logic [LEN_W-1:0]      a_addr_d;

  always_comb begin
    busy_d     = (state_d != CTRL_IDLE);
    done_d     = (state_d == CTRL_DONE);
    go_d       = (state_d == CTRL_RUN);
    zw_out_d   = go_d && zw_d;
    w_addr_d   = '0;
    w_row_en_d = '0;
    a_addr_d   = '0;
    arv_d      = '0;
    ocv_d      = '0;
    if (state_d == CTRL_LOAD_W) begin
      w_addr_d   = cnt_d[AW-1:0];
      w_row_en_d = ARRAY_SIZE'(1) << cnt_d[AW-1:0];
    end
    if (go_d) begin
      a_addr_d = (cnt_d < TW'(k_d)) ? cnt_d[LEN_W-1:0] : (k_d - LEN_W'(1));
      arv_d    = arv_raw;
      ocv_d    = ocv_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      go            <= 1'b0;
      z_weight      <= 1'b0;
      w_addr        <= '0;
      w_row_en      <= '0;
      a_addr        <= '0;
      a_row_valid   <= '0;
      out_col_valid <= '0;
    end else begin
      busy          <= busy_d;
      done          <= done_d;
      go            <= go_d;
      z_weight      <= zw_out_d;
      w_addr        <= w_addr_d;
      w_row_en      <= w_row_en_d;
      a_addr        <= a_addr_d;
      a_row_valid   <= arv_d;
      out_col_valid <= ocv_d;
    end
  end

endmodule
